// File: rtl/ks_pkg.sv
// Shared definitions for the serial Kogge-Stone adder: slice width and control states.
package ks_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ks_serial_adder_main_top.sv
// 8-bit combinational Kogge-Stone adder: log2(8)=3 prefix levels, carry-in folded in at the end.
module main_top (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g0_s, p0_s;
    logic [7:0] g1_s, p1_s;
    logic [7:0] g2_s, p2_s;
    logic [7:0] g3_s, p3_s;
    logic [8:0] c_s;

    assign g0_s = x & y;
    assign p0_s = x ^ y;

    // Prefix levels with spans 1, 2 and 4; low bits pass straight through.
    for (genvar i = 0; i < 8; i++) begin : g_lvl
        if (i >= 1) begin : g_l1
            assign g1_s[i] = g0_s[i] | (p0_s[i] & g0_s[i-1]);
            assign p1_s[i] = p0_s[i] & p0_s[i-1];
        end else begin : g_l1_pass
            assign g1_s[i] = g0_s[i];
            assign p1_s[i] = p0_s[i];
        end
        if (i >= 2) begin : g_l2
            assign g2_s[i] = g1_s[i] | (p1_s[i] & g1_s[i-2]);
            assign p2_s[i] = p1_s[i] & p1_s[i-2];
        end else begin : g_l2_pass
            assign g2_s[i] = g1_s[i];
            assign p2_s[i] = p1_s[i];
        end
        if (i >= 4) begin : g_l3
            assign g3_s[i] = g2_s[i] | (p2_s[i] & g2_s[i-4]);
            assign p3_s[i] = p2_s[i] & p2_s[i-4];
        end else begin : g_l3_pass
            assign g3_s[i] = g2_s[i];
            assign p3_s[i] = p2_s[i];
        end
        assign c_s[i+1] = g3_s[i] | (p3_s[i] & cin);
    end

    assign c_s[0] = cin;
    assign sum    = p0_s ^ c_s[7:0];
    assign cout   = c_s[8];

endmodule

// File: rtl/ks_serial_adder.sv
// Serial adder: one 8-bit Kogge-Stone slice per cycle, valid/ready on both sides.
module ks_serial_adder
    import ks_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NSLICE = WIDTH / SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int KW  = $clog2(NSLICE);
    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [SLICE_W-1:0] slice_x_s, slice_y_s, slice_sum_s;
    logic               slice_cout_s;
    logic               last_slice_s;

    // Index mux on k picks the active byte of each captured operand.
    assign slice_x_s    = a_q[k_q*SLICE_W +: SLICE_W];
    assign slice_y_s    = b_q[k_q*SLICE_W +: SLICE_W];
    assign last_slice_s = (k_q == KW'(NSLICE - 1));

    main_top u_slice (
        .x    (slice_x_s),
        .y    (slice_y_s),
        .cin  (carry_q),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    k_d     = {KW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[k_q*SLICE_W +: SLICE_W] = slice_sum_s;
                carry_d = slice_cout_s;
                k_d     = k_q + KW'(1'b1);
                if (last_slice_s) begin
                    // Top slice output byte holds the final sum MSB.
                    cout_d  = slice_cout_s;
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (slice_sum_s[SLICE_W-1] != a_q[MSB]);
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and result registers; reset wins over any same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= {KW{1'b0}};
            carry_q     <= 1'b0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ks_serial_adder.sv
// Directed self-checking bench for ks_serial_adder (WIDTH=32).
module tb_ks_serial_adder;

    localparam int WIDTH = 32;
    localparam int NS    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    ks_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        checks++;
        if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_res: sum=%h cout=%b ovf=%b required 0 0 0", sum, cout, ovf);
        end
    endtask

    // Full transaction with latency check; expects IDLE on entry.
    task automatic run_add(input string name, input logic [31:0] xa, input logic [31:0] xb,
                           input logic xc, input logic [31:0] es, input logic ec, input logic eo);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'hCAFEF00D; cin = 1'b1;
        for (int n = 1; n <= NS; n++) begin
            tick();
            if (n < NS) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_run%0d: out_valid=%b in_ready=%b required 0 0", name, n, out_valid, in_ready);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_lat: out_valid=%b in_ready=%b required 1 0", name, out_valid, in_ready);
        end
        checks++;
        if (sum !== es || cout !== ec || ovf !== eo) begin
            errors++;
            $display("FAIL %s_res: sum=%h cout=%b ovf=%b required %h %b %b", name, sum, cout, ovf, es, ec, eo);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        run_add("wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_add("posovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_add("mixed",  32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0);
        run_add("negovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        run_add("cinrip", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        run_add("bytecy", 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < NS; n++) tick();
        for (int n = 0; n < 10; n++) begin
            in_valid = n[0];
            a = 32'hFFFFFFFF - n; b = 32'h00000001 + n; cin = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h33333333 || cout !== 1'b0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b sum=%h cout=%b ovf=%b required 1 0 33333333 0 0",
                         n, out_valid, in_ready, sum, cout, ovf);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h33333333) begin
            errors++;
            $display("FAIL bp_release: ir=%b ov=%b sum=%h required 1 0 33333333", in_ready, out_valid, sum);
        end
    endtask

    task automatic test_mid_reset();
        a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrst: ir=%b ov=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midrst_quiet%0d: ov=%b ir=%b required 0 1", n, out_valid, in_ready);
            end
        end
        run_add("afterrst", 32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int t1 = -1;
        int t2 = -1;
        a = 32'h7FFFFFFF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 32'h0F0F0F0F; b = 32'hF0F0F0F1; cin = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (out_valid === 1'b1 && t1 < 0) begin
                t1 = n - 1;
                checks++;
                if (sum !== 32'h80000000 || cout !== 1'b0 || ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first: sum=%h cout=%b ovf=%b required 80000000 0 1", sum, cout, ovf);
                end
            end else if (out_valid === 1'b1 && t2 < 0 && t1 >= 0) begin
                t2 = n - 1;
                in_valid = 1'b0;
                checks++;
                if (sum !== 32'h00000000 || cout !== 1'b1 || ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second: sum=%h cout=%b ovf=%b required 00000000 1 0", sum, cout, ovf);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (t1 != NS) begin
            errors++;
            $display("FAIL b2b_lat: first result cycle=%0d required %0d", t1, NS);
        end
        checks++;
        if (t2 - t1 != NS + 2 || t2 < 0) begin
            errors++;
            $display("FAIL b2b_spacing: gap=%0d (t1=%0d t2=%0d) required %0d", t2 - t1, t1, t2, NS + 2);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: ir=%b ov=%b required 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ks_serial_adder.md
KS_SERIAL_ADDER -- requirements
Module: ks_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width; it SHALL be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter NSLICE, fixed at WIDTH/8, the number of 8-bit slices.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set a/b/cin presented.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  addend.
REQ-008 b  input  WIDTH  addend.
REQ-009 cin  input  1  carry-in to bit 0.
REQ-010 out_valid  output  1  result on sum/cout/ovf is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  two's-complement overflow flag.

Function
REQ-015 States SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1 and out_valid=0; on in_valid=1 the block SHALL register a, b and cin, clear the slice index k to 0 and go to RUN.
REQ-017 RUN: in_ready=0; each cycle one 8-bit Kogge-Stone slice SHALL add a[8k+7:8k] + b[8k+7:8k] + carry register.
REQ-018 RUN: the slice sum SHALL be written to sum[8k+7:8k], the carry register SHALL take the slice cout, and k SHALL increment.
REQ-019 The carry register SHALL be loaded with cin on acceptance.
REQ-020 After the slice with k=NSLICE-1, the block SHALL go to DONE, cout SHALL equal the final carry, and ovf SHALL equal (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
REQ-021 Latency: for a handshake at edge T, out_valid SHALL first be high in the cycle after edge T+NSLICE (32-bit: 4 RUN cycles).
REQ-022 DONE: out_valid=1 and in_ready=0; sum/cout/ovf SHALL hold stable until out_valid && out_ready, after which the block SHALL return to IDLE on the next edge.
REQ-023 Throughput SHALL be one result per NSLICE+2 cycles with out_ready held at 1.
REQ-024 in_valid in RUN or DONE SHALL be ignored; the captured operands SHALL NOT change.
REQ-025 sum, cout and ovf SHALL change only in RUN (slice writes) and on reset.
REQ-026 Carry wrap-around out of bit WIDTH-1 SHALL appear only on cout; sum wraps modulo 2^WIDTH.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, k=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0 and in_ready=1 after that edge, including mid-RUN and in DONE.
REQ-028 rst SHALL take priority over a same-cycle in_valid or out_ready; no partial result SHALL ever be presented.

Structure
REQ-029 Shared package ks_pkg SHALL hold SLICE_W=8 and the state enum (IDLE, RUN, DONE).
REQ-030 The block SHALL instantiate exactly one combinational main_top (8-bit Kogge-Stone; ports x, y, cin, sum, cout) as its slice datapath and SHALL contain no other adder.
REQ-031 Slice operand selection SHALL be an index mux on k, not a shift register.

Verification (WIDTH=32)
REQ-032 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0; out_valid first high in the cycle after edge T+4.
REQ-033 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-034 a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0, ovf=0.
REQ-035 Backpressure: result ready with out_ready=0 for 10 cycles while in_valid pulses with new operands -> out_valid, sum, cout and ovf stable, in_ready=0, new operands ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst=1 at edge T+2 mid-RUN -> after that edge IDLE, in_ready=1, out_valid=0, sum=0; a following add of 0x00000005+0x00000003 gives sum=0x00000008.
REQ-037 Back-to-back: two transactions with out_ready=1 -> results 6 cycles apart, each correct.
